// File: rtl/multicycle_control_unit_if.sv
// Fetch, register-file, ALU, data-memory and PC control bundle of the multi-cycle control unit.
// The master modport is the control unit; the slave modport is the datapath/fetch/memory side.
interface multicycle_control_unit_if #(
  parameter int OPC_W  = 4,
  parameter int REG_AW = 3,
  parameter int MEM_AW = 6,
  parameter int PC_W   = 8
);
  localparam int INSTR_W = OPC_W + 2 * REG_AW;

  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               instr_ready;
  logic               alu_zero;
  logic               mem_ack;
  logic [REG_AW-1:0]  addr_a;
  logic [REG_AW-1:0]  addr_b;
  logic               reg_reset;
  logic               reset_all;
  logic               load;
  logic               mb_select;
  logic [3:0]         alu_opcode;
  logic               mem_read;
  logic               mem_write;
  logic [MEM_AW-1:0]  mem_addr;
  logic               mem_select;
  logic               load_pc;
  logic [PC_W-1:0]    pc_value;
  logic               pc_inc;
  logic               out_valid;
  logic               halted;
  logic               mem_fault;

  modport master (
    input  instr_valid, instruction, alu_zero, mem_ack,
    output instr_ready, addr_a, addr_b, reg_reset, reset_all, load, mb_select,
           alu_opcode, mem_read, mem_write, mem_addr, mem_select, load_pc,
           pc_value, pc_inc, out_valid, halted, mem_fault
  );

  modport slave (
    output instr_valid, instruction, alu_zero, mem_ack,
    input  instr_ready, addr_a, addr_b, reg_reset, reset_all, load, mb_select,
           alu_opcode, mem_read, mem_write, mem_addr, mem_select, load_pc,
           pc_value, pc_inc, out_valid, halted, mem_fault
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/EXEC/MEMW/WB/HALT sequencer with registered controls,
// memory ack wait-states with timeout, JZ, HALT, OUT strobe and explicit PC increment.
module multicycle_control_unit #(
  parameter int OPC_W       = 4,
  parameter int REG_AW      = 3,
  parameter int MEM_AW      = 6,
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus
);
  localparam int INSTR_W = OPC_W + 2 * REG_AW;
  localparam int CNT_W   = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEMW, S_WB, S_HALT} state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_ADDI = 4'h2, OP_SUBI  = 4'h3,
    OP_MUL2 = 4'h4, OP_DIV2 = 4'h5, OP_CLR  = 4'h6, OP_RST   = 4'h7,
    OP_MOV  = 4'h8, OP_JMP  = 4'h9, OP_OUT  = 4'hA, OP_LOAD  = 4'hB,
    OP_STORE= 4'hC, OP_JZ   = 4'hD, OP_NOP  = 4'hE, OP_HALT  = 4'hF
  } op_e;

  typedef struct packed {
    logic              instr_ready;
    logic [REG_AW-1:0] addr_a;
    logic [REG_AW-1:0] addr_b;
    logic              reg_reset;
    logic              reset_all;
    logic              load;
    logic              mb_select;
    logic [3:0]        alu_opcode;
    logic              mem_read;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_select;
    logic              load_pc;
    logic [PC_W-1:0]   pc_value;
    logic              pc_inc;
    logic              out_valid;
    logic              halted;
  } ctrl_t;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  ctrl_t            out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  // Controls driven during EXEC for a freshly accepted instruction; the low opcode nibble is decoded.
  function automatic ctrl_t decode(input logic [INSTR_W-1:0] ins, input logic z);
    ctrl_t             d;
    op_e               op;
    logic [REG_AW-1:0] fa;
    logic [REG_AW-1:0] fb;
    d  = '0;
    op = op_e'(ins[2*REG_AW +: 4]);
    fa = ins[REG_AW +: REG_AW];
    fb = ins[0 +: REG_AW];
    case (op)
      OP_ADD, OP_SUB, OP_MOV: begin
        d.alu_opcode = (op == OP_MOV) ? 4'd4 : ((op == OP_SUB) ? 4'd1 : 4'd0);
        d.addr_a = fa; d.addr_b = fb; d.load = 1'b1; d.mb_select = 1'b1; d.pc_inc = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        d.alu_opcode = (op == OP_SUBI) ? 4'd1 : 4'd0;
        d.addr_a = fa; d.addr_b = fb; d.load = 1'b1; d.pc_inc = 1'b1;
      end
      OP_MUL2, OP_DIV2: begin
        d.alu_opcode = (op == OP_DIV2) ? 4'd3 : 4'd2;
        d.addr_a = fa; d.load = 1'b1; d.pc_inc = 1'b1;
      end
      OP_CLR:   begin d.reg_reset = 1'b1; d.addr_a = fa; d.pc_inc = 1'b1; end
      OP_RST:   begin d.reset_all = 1'b1; d.pc_inc = 1'b1; end
      OP_OUT:   begin d.out_valid = 1'b1; d.addr_a = fa; d.pc_inc = 1'b1; end
      OP_JMP:   begin d.load_pc = 1'b1; d.pc_value = PC_W'(ins[2*REG_AW-1:0]); end
      OP_JZ: begin
        if (z) begin d.load_pc = 1'b1; d.pc_value = PC_W'(ins[2*REG_AW-1:0]); end
        else d.pc_inc = 1'b1;
      end
      OP_LOAD:  begin d.mem_read  = 1'b1; d.mem_addr = ins[MEM_AW-1:0]; end
      OP_STORE: begin d.mem_write = 1'b1; d.mem_addr = ins[MEM_AW-1:0]; end
      OP_HALT:  d.halted = 1'b1;
      OP_NOP:   d.pc_inc = 1'b1;
      default:  d.pc_inc = 1'b1;
    endcase
    return d;
  endfunction

  // Outputs are registered, so every branch computes the control word for the coming cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    out_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (out_q.instr_ready && bus.instr_valid) begin
          op_d    = op_e'(bus.instruction[2*REG_AW +: 4]);
          cnt_d   = '0;
          out_d   = decode(bus.instruction, bus.alu_zero);
          state_d = (op_d == OP_HALT) ? S_HALT : S_EXEC;
        end else begin
          out_d.instr_ready = 1'b1;
        end
      end
      S_EXEC, S_MEMW: begin
        if (op_q == OP_LOAD || op_q == OP_STORE) begin
          if (bus.mem_ack) begin
            state_d      = S_WB;
            out_d.pc_inc = 1'b1;
            if (op_q == OP_LOAD) begin
              out_d.load       = 1'b1;
              out_d.mem_select = 1'b1;
            end
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_d      = S_HALT;
            out_d.halted = 1'b1;
            fault_d      = 1'b1;
          end else begin
            state_d = S_MEMW;
            out_d   = out_q;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d           = S_FETCH;
          out_d.instr_ready = 1'b1;
        end
      end
      S_WB: begin
        state_d           = S_FETCH;
        out_d.instr_ready = 1'b1;
      end
      S_HALT:  out_d.halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= OP_ADD;
      out_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign bus.instr_ready = out_q.instr_ready;
  assign bus.addr_a      = out_q.addr_a;
  assign bus.addr_b      = out_q.addr_b;
  assign bus.reg_reset   = out_q.reg_reset;
  assign bus.reset_all   = out_q.reset_all;
  assign bus.load        = out_q.load;
  assign bus.mb_select   = out_q.mb_select;
  assign bus.alu_opcode  = out_q.alu_opcode;
  assign bus.mem_read    = out_q.mem_read;
  assign bus.mem_write   = out_q.mem_write;
  assign bus.mem_addr    = out_q.mem_addr;
  assign bus.mem_select  = out_q.mem_select;
  assign bus.load_pc     = out_q.load_pc;
  assign bus.pc_value    = out_q.pc_value;
  assign bus.pc_inc      = out_q.pc_inc;
  assign bus.out_valid   = out_q.out_valid;
  assign bus.halted      = out_q.halted;
  assign bus.mem_fault   = fault_q;
endmodule
